fifo_rd_packer: RTL
===================

# fifo_rd_packer

Read-side consumer for the team's 16-deep FIFO. Pops `simd*bw`-wide entries whenever the FIFO is non-empty and packs `pack` consecutive entries into one wide word. It presents that word downstream on a valid/ready handshake, for example to a wide SRAM write port or a PE-array input bus. A `flush` input closes a partially filled word early.

## Interface
Parameters:
- `bw`, 8, bits per lane element
- `simd`, 1, elements per FIFO entry
- `pack`, 4, FIFO entries per output word (legal range 2..8)

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `reset_n`  input  1  reset, asynchronous, active-low
- `fifo_empty`  input  1  FIFO empty flag, same as FIFO `o_empty`
- `fifo_data`  input  simd*bw  FIFO head entry, same as FIFO `out`; combinational from the read pointer
- `fifo_rd`  output  1  pop request, same as FIFO `rd`
- `flush`  input  1  close the current partial word
- `o_data`  output  pack*simd*bw  packed word; entry k occupies bits [(k+1)*simd*bw-1 : k*simd*bw]
- `o_fill`  output  4  number of valid entries in `o_data` (1..pack while `o_valid`)
- `o_valid`  output  1  `o_data`/`o_fill` valid
- `i_ready`  input  1  downstream accepts the word

## Operation
- There are two states: FILL and HOLD. An entry counter `cnt` counts 0..pack-1.
- **FILL:**
  - `fifo_rd = ~fifo_empty`. This is combinational and is forced to 0 while `reset_n` is low.
  - On a clock edge with `fifo_rd=1`, the block captures `fifo_data` into lane `cnt` and increments `cnt`. The captured value is the FIFO head in that same cycle, because the FIFO advances its pointer on that edge.
  - When the capture fills lane pack-1, the block goes to HOLD with `o_fill=pack` and `cnt=0`.
- **flush in FILL:**
  - Flush takes effect only when the word would be non-empty after the edge, i.e. `cnt>0` or `fifo_rd=1`.
  - On a flush edge the block goes to HOLD with `o_fill` = entries captured, including any entry read on that same edge.
  - Flush with `cnt=0` and `fifo_rd=0` is ignored.
  - Unfilled lanes are 0.
- **HOLD:**
  - `o_valid=1` and `fifo_rd=0`.
  - `o_data` and `o_fill` stay stable until accepted.
  - On an edge with `i_ready=1`, the block returns to FILL, clears `o_data` to 0, and sets `o_fill` to 0.
  - `flush` is ignored in HOLD.
- `fifo_rd` never asserts while `fifo_empty=1`. Underflow is impossible by construction.
- Lane data is stored unmodified. There is no arithmetic on data. `o_fill` saturates at `pack`.
- **Reset** (async assert, synchronous deassert handled externally):
  - State returns to FILL and `cnt=0`.
  - `o_valid=0`, `o_data=0`, `o_fill=0`, `fifo_rd=0`.
  - A reset in the middle of a word discards any partial or held word.

## Timing
- Reads: one entry per cycle while `fifo_empty=0` in FILL.
- Latency:
  - `o_valid` rises on the edge that captures the pack-th entry (or the flush edge).
  - With `fifo_empty` constantly low, that is `pack` cycles after FILL entry.
- Handshake: the transfer happens on an edge with `o_valid & i_ready`. `o_valid` depends on state only, never combinationally on `i_ready`.
- Throughput: there is one bubble cycle per word. The first read of the next word occurs in the cycle after acceptance, so the peak rate is `pack` entries per `pack+1` cycles.
- Gaps: `fifo_empty` toggling only stalls reads; `cnt` and captured lanes are held.
- Combinational paths:
  - `fifo_rd` depends on `fifo_empty`, state and `reset_n` only.
  - `fifo_data` is registered on capture.
  - All other outputs are registered.

## Test plan
- **Reset:** drive `reset_n=0` mid-FILL with `cnt=2` → immediately `o_valid=0`, `o_data=0`, `o_fill=0`, `fifo_rd=0`. After release, the next word starts at lane 0.
- **Full pack** (pack=4, bw=8): FIFO holds 0x11,0x22,0x33,0x44, `i_ready=1` → `fifo_rd` is high for 4 consecutive cycles, then `o_valid=1` with `o_data=0x44332211` and `o_fill=4` for one cycle. `fifo_rd` re-asserts the following cycle.
- **Backpressure:** `i_ready=0` for 5 cycles while holding 0xDDCCBBAA → `o_data` is stable, `fifo_rd=0`, and the FIFO level is unchanged. Raising `i_ready` transfers exactly once.
- **Empty gaps:** `fifo_empty` alternates 1/0 while 0x01..0x04 are supplied → only 4 pops occur, and `o_data=0x04030201`, `o_fill=4`.
- **Flush:**
  - After 2 entries 0xAA,0xBB → `o_data=0x0000BBAA`, `o_fill=2`.
  - Flush coincident with the read of 0xCC → `o_data=0x00CCBBAA`, `o_fill=3`.
  - Flush with `cnt=0` and the FIFO empty → no `o_valid`.
- **Reset in HOLD:** `reset_n` is pulsed low while `o_valid=1` → the word is dropped and `o_valid=0`. The next 4 entries form a fresh word.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries while the FIFO is non-empty and packs
// `pack` of them into one wide word offered on a valid/ready handshake.
module fifo_rd_packer #(
  parameter int bw   = 8,
  parameter int simd = 1,
  parameter int pack = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fifo_empty,
  input  logic [simd*bw-1:0]       fifo_data,
  output logic                     fifo_rd,
  input  logic                     flush,
  output logic [pack*simd*bw-1:0]  o_data,
  output logic [3:0]               o_fill,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int EW = simd * bw;
  localparam int OW = pack * EW;
  localparam int CW = $clog2(pack);

  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [OW-1:0]   r_data;
  logic [OW-1:0]   w_data_nxt;
  logic [3:0]      r_fill;
  logic [3:0]      w_fill_nxt;
  logic            w_rd;
  logic            w_last;
  logic            w_flush_go;

  // Writes one entry into lane `lane`, leaving the other lanes untouched.
  function automatic logic [OW-1:0] lane_insert(input logic [OW-1:0] word,
                                                input logic [CW-1:0] lane,
                                                input logic [EW-1:0] entry);
    logic [OW-1:0] res;
    res = word;
    for (int k = 0; k < pack; k++) begin
      if (k == int'(lane)) res[k*EW +: EW] = entry;
    end
    return res;
  endfunction

  // Entries held once this edge completes: those already captured plus the
  // one being read now.
  function automatic logic [3:0] fill_count(input logic [CW-1:0] cnt,
                                            input logic          rd);
    return 4'(cnt) + {3'b000, rd};
  endfunction

  // Pop only while collecting and the FIFO has data; reset overrides.
  assign w_rd       = (r_state == S_FILL) & ~fifo_empty & reset_n;
  assign w_last     = w_rd & (r_cnt == CW'(pack - 1));
  assign w_flush_go = flush & ((r_cnt != '0) | w_rd);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_fill_nxt  = r_fill;
    case (r_state)
      S_FILL: begin
        if (w_rd) begin
          w_data_nxt = lane_insert(r_data, r_cnt, fifo_data);
          w_cnt_nxt  = r_cnt + CW'(1);
        end
        if (w_last || w_flush_go) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_fill_nxt  = fill_count(r_cnt, w_rd);
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          w_state_nxt = S_FILL;
          w_data_nxt  = '0;
          w_fill_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
        w_data_nxt  = '0;
        w_fill_nxt  = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rd = w_rd;
    o_valid = (r_state == S_HOLD);
  end

  assign o_data = r_data;
  assign o_fill = r_fill;

endmodule
